uart_boot_ctrl: RTL and testbench

SoC-side boot-load sequencer for BrqRV_EB1. It consumes the byte stream from the UART receiver, assembles bytes MSB-first into 32-bit instruction words, and writes them to instruction memory through a req/gnt port. The end marker 32'h00000FFF stops the load. It holds the core in reset until loading completes, and drives the loader-ready handshake seen by the external programmer.

---
 rtl/uart_boot_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_boot_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_ctrl.sv
// Boot-load sequencer: assembles UART bytes MSB-first into words and writes them to instruction memory.
// Optional inter-byte timeout is enabled by defining BOOT_RX_TIMEOUT_EN.
module uart_boot_ctrl #(
    parameter int          AW             = 12,
    parameter int          BASE_ADDR      = 0,
    parameter int          MAX_WORDS      = 4096,
    parameter logic [31:0] END_WORD       = 32'h00000FFF,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic          i_clk,
    input  logic          i_rst_l,
    input  logic          i_boot_en,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_data,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic          i_mem_gnt,
    output logic          o_ldr_ready,
    output logic          o_core_rst_l,
    output logic          o_prog_done,
    output logic [AW:0]   o_word_count,
    output logic          o_overrun,
    output logic          o_overflow,
    output logic          o_rx_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);
    localparam logic [AW:0]   MAX_CNT = (AW + 1)'(MAX_WORDS);

    state_t        r_state;
    logic [23:0]   r_shift;
    logic [1:0]    r_byte_cnt;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_ldr_ready;
    logic          r_core_rst_l;
    logic          r_prog_done;
    logic [AW:0]   r_word_count;
    logic          r_overrun;
    logic          r_overflow;

    logic [31:0]   w_word;
    logic          w_last_byte;

    assign w_word      = {r_shift, i_rx_data};
    assign w_last_byte = (r_byte_cnt == 2'd3);

`ifdef BOOT_RX_TIMEOUT_EN
    localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_rx_timeout;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_l) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= BASE;
            r_mem_wdata  <= '0;
            r_ldr_ready  <= 1'b0;
            r_core_rst_l <= 1'b0;
            r_prog_done  <= 1'b0;
            r_word_count <= '0;
            r_overrun    <= 1'b0;
            r_overflow   <= 1'b0;
`ifdef BOOT_RX_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_rx_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mem_req   <= 1'b0;
                    r_ldr_ready <= 1'b0;
                    if (i_boot_en) begin
                        r_state      <= S_RECV;
                        r_shift      <= '0;
                        r_byte_cnt   <= '0;
                        r_mem_addr   <= BASE;
                        r_ldr_ready  <= 1'b1;
                        r_core_rst_l <= 1'b0;
                        r_prog_done  <= 1'b0;
                        r_word_count <= '0;
                        r_overrun    <= 1'b0;
                        r_overflow   <= 1'b0;
`ifdef BOOT_RX_TIMEOUT_EN
                        r_tmo_cnt    <= '0;
                        r_rx_timeout <= 1'b0;
`endif
                    end
                end
                S_RECV: begin
                    if (i_rx_valid) begin
                        r_shift    <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef BOOT_RX_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                        if (w_last_byte) begin
                            r_ldr_ready <= 1'b0;
                            if (w_word == END_WORD) begin
                                r_state      <= S_DONE;
                                r_prog_done  <= 1'b1;
                                r_core_rst_l <= 1'b1;
                            end else if (r_word_count == MAX_CNT) begin
                                r_state    <= S_ERR;
                                r_overflow <= 1'b1;
                            end else begin
                                r_state     <= S_WRITE;
                                r_mem_wdata <= w_word;
                                r_mem_req   <= 1'b1;
                            end
                        end
                    end
`ifdef BOOT_RX_TIMEOUT_EN
                    // A stalled partial word is discarded so the stream can resynchronise.
                    else if (r_byte_cnt != 2'd0) begin
                        if (r_tmo_cnt == TMO_LAST) begin
                            r_tmo_cnt    <= '0;
                            r_byte_cnt   <= '0;
                            r_shift      <= '0;
                            r_rx_timeout <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= '0;
                    end
`endif
                end
                S_WRITE: begin
                    if (i_rx_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (i_mem_gnt) begin
                        r_mem_req    <= 1'b0;
                        r_mem_addr   <= r_mem_addr + 1'b1;
                        r_word_count <= r_word_count + 1'b1;
                        r_ldr_ready  <= 1'b1;
                        r_state      <= S_RECV;
                    end
                end
                S_DONE: begin
                    r_ldr_ready <= 1'b0;
                end
                S_ERR: begin
                    r_ldr_ready  <= 1'b0;
                    r_core_rst_l <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase

            // Abort overrides the state logic above; a same-cycle grant still counts.
            if (r_state != S_IDLE && !i_boot_en) begin
                r_state     <= S_IDLE;
                r_mem_req   <= 1'b0;
                r_ldr_ready <= 1'b0;
                r_byte_cnt  <= '0;
                r_shift     <= '0;
`ifdef BOOT_RX_TIMEOUT_EN
                r_tmo_cnt   <= '0;
`endif
            end
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_ldr_ready  = r_ldr_ready;
    assign o_core_rst_l = r_core_rst_l;
    assign o_prog_done  = r_prog_done;
    assign o_word_count = r_word_count;
    assign o_overrun    = r_overrun;
    assign o_overflow   = r_overflow;
`ifdef BOOT_RX_TIMEOUT_EN
    assign o_rx_timeout = r_rx_timeout;
`else
    // No timeout hardware; the parameter is referenced only to keep the interface identical.
    assign o_rx_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed self-checking bench for uart_boot_ctrl; a second instance with MAX_WORDS=2 covers overflow.
module tb_uart_boot_ctrl;

    logic        clk;
    logic        rstL;
    logic        bootEn;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        memGnt;
    logic        memReq;
    logic [11:0] memAddr;
    logic [31:0] memWdata;
    logic        ldrReady;
    logic        coreRstL;
    logic        progDone;
    logic [12:0] wordCount;
    logic        overrun;
    logic        overflow;
    logic        rxTimeout;

    logic        ovfGnt;
    logic        ovfReq;
    logic [11:0] ovfAddr;
    logic [31:0] ovfWdata;
    logic        ovfLdrReady;
    logic        ovfCoreRstL;
    logic        ovfProgDone;
    logic [12:0] ovfWordCount;
    logic        ovfOverrun;
    logic        ovfOverflow;
    logic        ovfRxTimeout;
    int          ovfGrants;

    int assertCount = 0;
    int failCount   = 0;

    uart_boot_ctrl #(.TIMEOUT_CYCLES(50)) dut (
        .i_clk(clk), .i_rst_l(rstL), .i_boot_en(bootEn),
        .i_rx_valid(rxValid), .i_rx_data(rxData),
        .o_mem_req(memReq), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
        .i_mem_gnt(memGnt), .o_ldr_ready(ldrReady), .o_core_rst_l(coreRstL),
        .o_prog_done(progDone), .o_word_count(wordCount), .o_overrun(overrun),
        .o_overflow(overflow), .o_rx_timeout(rxTimeout)
    );

    uart_boot_ctrl #(.MAX_WORDS(2), .TIMEOUT_CYCLES(50)) dutOvf (
        .i_clk(clk), .i_rst_l(rstL), .i_boot_en(bootEn),
        .i_rx_valid(rxValid), .i_rx_data(rxData),
        .o_mem_req(ovfReq), .o_mem_addr(ovfAddr), .o_mem_wdata(ovfWdata),
        .i_mem_gnt(ovfGnt), .o_ldr_ready(ovfLdrReady), .o_core_rst_l(ovfCoreRstL),
        .o_prog_done(ovfProgDone), .o_word_count(ovfWordCount), .o_overrun(ovfOverrun),
        .o_overflow(ovfOverflow), .o_rx_timeout(ovfRxTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The overflow instance gets an automatic grant one cycle after each request.
    always @(posedge clk) begin
        if (!rstL) begin
            ovfGnt    <= 1'b0;
            ovfGrants <= 0;
        end else begin
            ovfGnt <= ovfReq && !ovfGnt;
            if (ovfReq && ovfGnt) ovfGrants <= ovfGrants + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) applyStimulus(w[i*8 +: 8]);
    endtask

    task automatic serviceWrite(input logic [11:0] expAddr, input logic [31:0] expData,
                                input int gntDelay, input bit inject);
        int waitCycles = 0;
        while (!memReq && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("mem_req_rise", memReq, 1);
        checkOutput("mem_addr", memAddr, expAddr);
        checkOutput("mem_wdata", memWdata, expData);
        checkOutput("ldr_ready_in_write", ldrReady, 0);
        for (int i = 0; i < gntDelay; i++) begin
            if (inject && i == 0) begin
                rxValid = 1'b1;
                rxData  = 8'hAA;
            end
            @(negedge clk);
            rxValid = 1'b0;
            checkOutput("mem_req_hold", memReq, 1);
        end
        memGnt = 1'b1;
        @(negedge clk);
        memGnt = 1'b0;
        checkOutput("mem_req_drop", memReq, 0);
        checkOutput("ldr_ready_after_gnt", ldrReady, 1);
    endtask

    task automatic doReset();
        rstL   = 1'b0;
        bootEn = 1'b0;
        repeat (2) @(negedge clk);
        rstL = 1'b1;
        @(negedge clk);
    endtask

    task automatic startLoad();
        bootEn = 1'b1;
        @(negedge clk);
        checkOutput("ldr_ready_recv", ldrReady, 1);
    endtask

    initial begin
        rstL    = 1'b0;
        bootEn  = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'h00;
        memGnt  = 1'b0;
        @(negedge clk);
        doReset();
        checkOutput("rst_mem_req", memReq, 0);
        checkOutput("rst_mem_addr", memAddr, 0);
        checkOutput("rst_mem_wdata", memWdata, 0);
        checkOutput("rst_ldr_ready", ldrReady, 0);
        checkOutput("rst_core_rst_l", coreRstL, 0);
        checkOutput("rst_prog_done", progDone, 0);
        checkOutput("rst_word_count", wordCount, 0);
        checkOutput("rst_flags", {overrun, overflow, rxTimeout}, 0);

        $display("[TB] single word then end marker");
        startLoad();
        sendWord(32'h13000093);
        checkOutput("req_latency", memReq, 1);
        serviceWrite(12'd0, 32'h13000093, 2, 1'b0);
        checkOutput("wc_after_first", wordCount, 1);
        sendWord(32'h00000FFF);
        checkOutput("done_prog_done", progDone, 1);
        checkOutput("done_core_rst_l", coreRstL, 1);
        checkOutput("done_ldr_ready", ldrReady, 0);
        checkOutput("done_word_count", wordCount, 1);
        checkOutput("done_no_req", memReq, 0);
        bootEn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_core_rst_held", coreRstL, 1);
        checkOutput("idle_prog_done_held", progDone, 1);

        $display("[TB] three words, delayed grants, overrun");
        startLoad();
        checkOutput("reentry_core_rst_l", coreRstL, 0);
        checkOutput("reentry_word_count", wordCount, 0);
        sendWord(32'hA1B2C3D4);
        serviceWrite(12'd0, 32'hA1B2C3D4, 5, 1'b1);
        checkOutput("overrun_set", overrun, 1);
        sendWord(32'h11223344);
        serviceWrite(12'd1, 32'h11223344, 5, 1'b0);
        sendWord(32'h55667788);
        serviceWrite(12'd2, 32'h55667788, 5, 1'b0);
        sendWord(32'h00000FFF);
        checkOutput("three_word_count", wordCount, 3);
        checkOutput("three_prog_done", progDone, 1);
        checkOutput("three_overrun_sticky", overrun, 1);

        $display("[TB] abort discards partial word");
        bootEn = 1'b0;
        @(negedge clk);
        startLoad();
        checkOutput("abort_overrun_cleared", overrun, 0);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        bootEn = 1'b0;
        @(negedge clk);
        checkOutput("abort_ldr_ready", ldrReady, 0);
        startLoad();
        sendWord(32'h00000FFF);
        checkOutput("abort_done", progDone, 1);
        checkOutput("abort_word_count", wordCount, 0);
        checkOutput("abort_no_req", memReq, 0);

        $display("[TB] reset during write");
        bootEn = 1'b0;
        @(negedge clk);
        startLoad();
        sendWord(32'hDEADBEEF);
        checkOutput("pre_reset_req", memReq, 1);
        rstL   = 1'b0;
        memGnt = 1'b1;
        bootEn = 1'b0;
        @(negedge clk);
        memGnt = 1'b0;
        checkOutput("midrst_mem_req", memReq, 0);
        checkOutput("midrst_word_count", wordCount, 0);
        checkOutput("midrst_mem_addr", memAddr, 0);
        checkOutput("midrst_mem_wdata", memWdata, 0);
        checkOutput("midrst_prog_done", progDone, 0);
        rstL = 1'b1;
        @(negedge clk);

        $display("[TB] overflow with MAX_WORDS=2");
        startLoad();
        sendWord(32'h00000001);
        serviceWrite(12'd0, 32'h00000001, 1, 1'b0);
        sendWord(32'h00000002);
        serviceWrite(12'd1, 32'h00000002, 1, 1'b0);
        sendWord(32'h00000003);
        serviceWrite(12'd2, 32'h00000003, 1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ovf_grants", ovfGrants, 2);
        checkOutput("ovf_word_count", ovfWordCount, 2);
        checkOutput("ovf_overflow", ovfOverflow, 1);
        checkOutput("ovf_core_rst_l", ovfCoreRstL, 0);
        checkOutput("ovf_ldr_ready", ovfLdrReady, 0);
        checkOutput("ovf_no_req", ovfReq, 0);
        checkOutput("main_no_overflow", overflow, 0);
        checkOutput("main_word_count", wordCount, 3);

        $display("[TB] inter-byte gap");
        doReset();
        startLoad();
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        repeat (60) @(negedge clk);
`ifdef BOOT_RX_TIMEOUT_EN
        checkOutput("gap_rx_timeout", rxTimeout, 1);
        sendWord(32'hA1B2C3D4);
        serviceWrite(12'd0, 32'hA1B2C3D4, 1, 1'b0);
`else
        checkOutput("gap_rx_timeout", rxTimeout, 0);
        sendWord(32'hA1B2C3D4);
        serviceWrite(12'd0, 32'h1234A1B2, 1, 1'b0);
        checkOutput("gap_rx_timeout_after", rxTimeout, 0);
`endif
        checkOutput("gap_word_count", wordCount, 1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
